vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Video timing generator clocked by the ~25.17 MHz pixel clock from the system PLL (output clock 1).
- Produces hsync, vsync, data-enable and pixel coordinates for the downstream pixel/framebuffer stage.
- Qualified by the PLL `locked` output; timing starts cleanly from pixel (0,0) once the clock is stable.
- Default mode is 640x480@60 (800x525 total).

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active low)
- VS_POL, 0, vsync active level (0 = active low)
- CNT_W, 10, width of counters and coordinate outputs; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  in  1  pixel clock (PLL outclk_1)
- rst_n  in  1  synchronous reset, active low
- locked  in  1  PLL lock; counting enabled only while high
- hsync  out  1  horizontal sync, polarity per HS_POL
- vsync  out  1  vertical sync, polarity per VS_POL
- de  out  1  high during active pixels
- x  out  CNT_W  current horizontal count (pixel column)
- y  out  CNT_W  current vertical count (line)
- line_start  out  1  one-cycle pulse at h count 0 of every line
- frame_start  out  1  one-cycle pulse at h=0, v=0

Behaviour:
- Derived sizes: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Region order within each axis: active, front porch, sync, back porch.
- Internal counters:
  - h_cnt wraps H_TOTAL-1 -> 0.
  - v_cnt increments only when h_cnt wraps; v_cnt wraps V_TOTAL-1 -> 0 on the same cycle h_cnt wraps.
- Outputs are registered, with 1-cycle latency: outputs in cycle t+1 decode the counters of cycle t.
  - x = h_cnt, y = v_cnt.
  - de = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hsync active iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync active iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC. vsync changes aligned to h_cnt = 0 (no mid-line edge).
  - line_start = (h_cnt == 0); frame_start = (h_cnt == 0 && v_cnt == 0).
- Reset (rst_n low at a clock edge) and idle (locked low):
  - counters = 0; de = 0; x = 0; y = 0.
  - hsync = ~HS_POL; vsync = ~VS_POL.
  - line_start = 0; frame_start = 0.
- Reset takes priority over locked.
- Start-up:
  - First clock edge with rst_n high and locked high: counters run from (0,0).
  - The next cycle shows x=0, y=0, de=1, line_start=1, frame_start=1.
- locked falling mid-frame: next edge returns to the idle state above. Relocking restarts a full frame from (0,0); no partial frame is resumed.
- reset mid-frame: same as the locked-fall case.
- Widths: comparisons are unsigned at CNT_W bits. No saturation is required; parameters guarantee H_TOTAL, V_TOTAL <= 2^CNT_W.
- Steady state:
  - exactly H_ACTIVE de cycles per active line;
  - H_TOTAL*V_TOTAL cycles between frame_start pulses (420000 at defaults).

Decomposition:
- Package vga_timing_pkg holds:
  - the default 640x480 mode constants (H_*/V_* values, totals);
  - a helper function computing the total from active/fp/sync/bp.
- One sub-module is natural: video_axis_cnt.
  - Parameterised counter with wrap output and active/sync region decode.
  - Instantiated once for the horizontal axis and once for the vertical axis; the vertical instance is enabled by the horizontal wrap.

Test Plan:
- Idle/reset: rst_n=0, then locked=0 with rst_n=1 -> hsync=1, vsync=1, de=0, x=0, y=0, no pulses, for 1000 cycles.
- Start-up: locked rises at cycle T -> at T+1 (output cycle), frame_start=1, line_start=1, de=1, x=0, y=0; x=639 at T+640; de falls at T+641.
- Line timing (defaults): hsync low for output x = 656..751 (96 cycles); line_start period = 800 cycles; de high 640 cycles per line for y < 480, 0 for y >= 480.
- Frame timing: vsync low exactly on lines y = 490..491 (1600 cycles), edges coincide with x = 0; frame_start period = 420000 cycles; y wraps 524 -> 0.
- Mid-frame loss: drop locked at y=200, x=300 -> next cycle idle outputs; reassert after 50 cycles -> frame_start with x=0, y=0 one cycle later.
- Small mode, HS_POL=1: H=8/2/2/2, V=4/1/1/1 -> hsync high for x = 10..11, vsync high on y = 5, frame period 14*7 = 98 cycles.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared constants for the video timing generator.
// Holds the default 640x480@60 mode and the helper that sums the four regions of one axis.
package vga_timing_pkg;

    function automatic int unsigned axis_total(
        input int unsigned active,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        return active + fp + sync + bp;
    endfunction

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam int unsigned DEF_CNT_W    = 10;

    localparam int unsigned DEF_H_TOTAL =
        axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int unsigned DEF_V_TOTAL =
        axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/video_axis_cnt.sv
// One timing axis: wrapping counter with active-region and sync-region decode.
// The wrap output is qualified by the enable so it can step the next axis directly.
module video_axis_cnt
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned FP     = DEF_H_FP,
    parameter int unsigned SYNC   = DEF_H_SYNC,
    parameter int unsigned BP     = DEF_H_BP,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_wrap,
    output logic             o_active,
    output logic             o_sync
);

    localparam int unsigned TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);
    // Region bounds carry one spare bit so a bound equal to 2^CNT_W does not alias to zero.
    localparam logic [CNT_W:0] ACT_END  = (CNT_W+1)'(ACTIVE);
    localparam logic [CNT_W:0] SYNC_BEG = (CNT_W+1)'(ACTIVE + FP);
    localparam logic [CNT_W:0] SYNC_END = (CNT_W+1)'(ACTIVE + FP + SYNC);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;
    logic [CNT_W:0]   w_cnt_ext;

    assign w_last    = (r_cnt == LAST);
    assign w_cnt_ext = {1'b0, r_cnt};

    // Count while enabled, wrap after the last position, hold at zero while cleared.
    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt    = r_cnt;
    assign o_wrap   = i_en & w_last;
    assign o_active = (w_cnt_ext < ACT_END);
    assign o_sync   = (w_cnt_ext >= SYNC_BEG) && (w_cnt_ext < SYNC_END);

endmodule

// File: rtl/vga_timing_gen.sv
// Video timing generator: hsync/vsync/de and pixel coordinates from the pixel clock.
// Runs only while the PLL reports lock; any loss of lock or reset restarts at pixel (0,0).
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             locked,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start
);

    logic [CNT_W-1:0] w_h_cnt;
    logic [CNT_W-1:0] w_v_cnt;
    logic             w_h_wrap;
    logic             w_v_wrap_unused;
    logic             w_h_active;
    logic             w_v_active;
    logic             w_h_sync;
    logic             w_v_sync;
    logic             w_h_first;
    logic             w_v_first;

    logic             r_hsync;
    logic             r_vsync;
    logic             r_de;
    logic [CNT_W-1:0] r_x;
    logic [CNT_W-1:0] r_y;
    logic             r_line_start;
    logic             r_frame_start;

    video_axis_cnt #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .CNT_W  (CNT_W)
    ) u_h_axis (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (!locked),
        .i_en     (locked),
        .o_cnt    (w_h_cnt),
        .o_wrap   (w_h_wrap),
        .o_active (w_h_active),
        .o_sync   (w_h_sync)
    );

    // The vertical axis only steps on the horizontal wrap, so vsync edges land on h=0.
    video_axis_cnt #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .CNT_W  (CNT_W)
    ) u_v_axis (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (!locked),
        .i_en     (w_h_wrap),
        .o_cnt    (w_v_cnt),
        .o_wrap   (w_v_wrap_unused),
        .o_active (w_v_active),
        .o_sync   (w_v_sync)
    );

    assign w_h_first = (w_h_cnt == '0);
    assign w_v_first = (w_v_cnt == '0);

    // Register the decode of the current counters; idle levels while reset or unlocked.
    always_ff @(posedge clk) begin
        if (!rst_n || !locked) begin
            r_hsync       <= ~HS_POL;
            r_vsync       <= ~VS_POL;
            r_de          <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hsync       <= w_h_sync ? HS_POL : ~HS_POL;
            r_vsync       <= w_v_sync ? VS_POL : ~VS_POL;
            r_de          <= w_h_active && w_v_active;
            r_x           <= w_h_cnt;
            r_y           <= w_v_cnt;
            r_line_start  <= w_h_first;
            r_frame_start <= w_h_first && w_v_first;
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign x           = r_x;
    assign y           = r_y;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule
